fs_serial_ctrl: RTL and testbench
=================================

FS_SERIAL_CTRL -- requirements
Module: fs_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a_in  input  WIDTH  minuend, captured on accepted start.
REQ-006 SHALL have port b_in  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 SHALL have port bin  input  1  initial borrow-in, captured on accepted start.
REQ-008 SHALL have port fs_a  output  1  minuend bit to external full-subtractor cell.
REQ-009 SHALL have port fs_b  output  1  subtrahend bit to cell.
REQ-010 SHALL have port fs_c  output  1  borrow-in to cell.
REQ-011 SHALL have port fs_d  input  1  difference bit from cell (combinational return).
REQ-012 SHALL have port fs_br  input  1  borrow-out from cell (combinational return).
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port diff  output  WIDTH  result a_in - b_in - bin, modulo 2^WIDTH.
REQ-016 SHALL have port bout  output  1  final borrow-out (1 = result negative or underflow).

Function
REQ-017 SHALL implement FSM with states IDLE, RUN, DONE; all outputs registered except fs_a/fs_b/fs_c.
REQ-018 IDLE: start=1 at edge -> latch a_in, b_in into shift regs, borrow reg <= bin, bit counter <= 0, go RUN; start=0 -> stay IDLE.
REQ-019 RUN: fs_a = a_shift[0], fs_b = b_shift[0], fs_c = borrow reg; in IDLE/DONE fs_a/fs_b/fs_c SHALL be 0.
REQ-020 RUN, each edge: shift a/b right by 1; shift fs_d into diff shift reg at MSB (LSB processed first); borrow reg <= fs_br; counter +1.
REQ-021 RUN edge with counter = WIDTH-1 -> go DONE; diff then holds all WIDTH bits in correct order, bout <= fs_br.
REQ-022 Latency: start accepted at edge k -> done high from edge k+WIDTH+1 to edge k+WIDTH+2 (exactly one cycle).
REQ-023 DONE: done=1, busy=0, next edge -> IDLE unconditionally.
REQ-024 start in RUN or DONE SHALL be ignored (no re-latch, no queueing); start high in IDLE next cycle after DONE SHALL be accepted.
REQ-025 diff and bout SHALL hold last result unchanged through IDLE until the end of the next operation's DONE transition; diff shift updates internal only, diff output updates at RUN->DONE edge.
REQ-026 a_in/b_in/bin changes after acceptance SHALL not affect the operation in flight.
REQ-027 Counter SHALL be ceil(log2(WIDTH)) bits minimum, no wrap inside one operation.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow reg=0, shift regs=0, fs_a/fs_b/fs_c=0.
REQ-029 Reset mid-RUN SHALL abort the operation with no done pulse; first start after rst_n release SHALL be accepted normally.

Verification
REQ-030 WIDTH=8, a=5, b=3, bin=0, start one cycle, real full-subtractor cell attached -> busy 8 cycles, done at k+9, diff=0x02, bout=0.
REQ-031 WIDTH=8, a=3, b=5, bin=0 -> diff=0xFE, bout=1; a=0, b=0, bin=1 -> diff=0xFF, bout=1.
REQ-032 start held high continuously from IDLE -> operations back-to-back, exactly one done per WIDTH+2 cycles, inputs changed during RUN ignored.
REQ-033 rst_n pulsed low at RUN bit 4 -> all outputs 0 asynchronously, no done; next start a=0xAA, b=0x55 -> diff=0x55, bout=0.
REQ-034 Exhaustive WIDTH=4 sweep (all a, b, bin) vs reference model a-b-bin -> diff and bout match on every done; fs_a/fs_b/fs_c=0 outside RUN.

Source files
------------

// File: rtl/fs_serial_ctrl_if.sv
// rtl/fs_serial_ctrl_if.sv - request/result and full-subtractor cell signals of fs_serial_ctrl
interface fs_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin;
  logic             fs_a;
  logic             fs_b;
  logic             fs_c;
  logic             fs_d;
  logic             fs_br;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // master: requester that also hosts the external full-subtractor cell
  modport master (
    output start, a_in, b_in, bin, fs_d, fs_br,
    input  fs_a, fs_b, fs_c, busy, done, diff, bout
  );

  modport slave (
    input  start, a_in, b_in, bin, fs_d, fs_br,
    output fs_a, fs_b, fs_c, busy, done, diff, bout
  );
endinterface

// File: rtl/fs_serial_ctrl.sv
// rtl/fs_serial_ctrl.sv - bit-serial subtractor driving an external full-subtractor cell, LSB first
module fs_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  fs_serial_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fs_a, fs_b, fs_c;
  logic             last_bit;
  logic [WIDTH-1:0] d_shifted;

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  assign d_shifted = {bus.fs_d, d_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the current state, so they trail it by one cycle
  always_comb begin
    busy_d = (state_q == RUN);
    done_d = (state_q == DONE);
    fs_a   = 1'b0;
    fs_b   = 1'b0;
    fs_c   = 1'b0;
    if (state_q == RUN) begin
      fs_a = a_sh_q[0];
      fs_b = b_sh_q[0];
      fs_c = borrow_q;
    end
  end

  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE && bus.start) begin
      a_sh_d   = bus.a_in;
      b_sh_d   = bus.b_in;
      borrow_d = bus.bin;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      d_sh_d   = d_shifted;
      borrow_d = bus.fs_br;
      cnt_d    = cnt_q + CW'(1);
      if (last_bit) begin
        diff_d = d_shifted;
        bout_d = bus.fs_br;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.fs_a = fs_a;
  assign bus.fs_b = fs_b;
  assign bus.fs_c = fs_c;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_fs_serial_ctrl.sv
// tb/tb_fs_serial_ctrl.sv - directed and exhaustive checks of fs_serial_ctrl with a real full-subtractor cell
module tb_fs_serial_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fs_serial_ctrl_if #(.WIDTH(8)) b8 ();
  fs_serial_ctrl_if #(.WIDTH(4)) b4 ();

  fs_serial_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  fs_serial_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  assign b8.fs_d  = b8.fs_a ^ b8.fs_b ^ b8.fs_c;
  assign b8.fs_br = (~b8.fs_a & b8.fs_b) | (~(b8.fs_a ^ b8.fs_b) & b8.fs_c);
  assign b4.fs_d  = b4.fs_a ^ b4.fs_b ^ b4.fs_c;
  assign b4.fs_br = (~b4.fs_a & b4.fs_b) | (~(b4.fs_a ^ b4.fs_b) & b4.fs_c);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] exp_d, input logic exp_bo);
    int c;
    int nbusy;
    b8.a_in  = a;
    b8.b_in  = b;
    b8.bin   = bi;
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    check("fs_a_bit0", b8.fs_a, a[0]);
    check("fs_b_bit0", b8.fs_b, b[0]);
    check("fs_c_bit0", b8.fs_c, bi);
    b8.a_in = ~a;
    b8.b_in = ~b;
    b8.bin  = ~bi;
    nbusy = 0;
    for (c = 1; c <= 30; c++) begin
      tick();
      if (b8.busy) nbusy++;
      if (b8.done) break;
    end
    check("done_latency", c, 9);
    check("busy_cycles", nbusy, 8);
    check("diff", b8.diff, exp_d);
    check("bout", b8.bout, exp_bo);
    check("fs_idle", {b8.fs_a, b8.fs_b, b8.fs_c}, 3'b000);
    tick();
    check("done_one_cycle", b8.done, 1'b0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    logic [4:0] r;
    int c;
    r = {1'b0, a} - {1'b0, b} - {4'd0, bi};
    b4.a_in  = a;
    b4.b_in  = b;
    b4.bin   = bi;
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    for (c = 1; c <= 12; c++) begin
      tick();
      if (b4.done) break;
    end
    check("w4_result", {27'd0, b4.bout, b4.diff, (c == 5) ? 1'b1 : 1'b0}, {27'd0, r, 1'b1});
    check("w4_fs_idle", {b4.fs_a, b4.fs_b, b4.fs_c}, 3'b000);
    tick();
  endtask

  initial begin
    int ndone;
    int first_done;
    int last_gap;
    int ok_gap;
    int ok_res;
    rst_n    = 1'b0;
    b8.start = 1'b0; b8.a_in = '0; b8.b_in = '0; b8.bin = 1'b0;
    b4.start = 1'b0; b4.a_in = '0; b4.b_in = '0; b4.bin = 1'b0;
    #1;
    check("rst_outputs", {b8.busy, b8.done, b8.bout, b8.fs_a, b8.fs_b, b8.fs_c}, 6'd0);
    check("rst_diff", b8.diff, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_no_start", {b8.busy, b8.done}, 2'b00);

    run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    check("hold_idle_diff", b8.diff, 8'h02);
    run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    run8(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1);

    // start held high: scrambled inputs while busy, real operands only when not busy
    b8.a_in = 8'h10; b8.b_in = 8'h01; b8.bin = 1'b0;
    b8.start = 1'b1;
    ndone = 0; first_done = 0; last_gap = 0; ok_gap = 1; ok_res = 1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (b8.done) begin
        if (ndone == 0) first_done = c;
        else if (c - last_gap != 10) ok_gap = 0;
        if (b8.diff !== 8'h0F || b8.bout !== 1'b0) ok_res = 0;
        last_gap = c;
        ndone++;
      end
      if (b8.busy) begin
        b8.a_in = 8'($urandom); b8.b_in = 8'($urandom); b8.bin = 1'($urandom);
      end else begin
        b8.a_in = 8'h10; b8.b_in = 8'h01; b8.bin = 1'b0;
      end
    end
    b8.start = 1'b0;
    check("b2b_done_count", ndone, 3);
    check("b2b_first_done", first_done, 10);
    check("b2b_spacing", ok_gap, 1);
    check("b2b_results", ok_res, 1);
    tick();
    tick();
    check("b2b_idle", {b8.busy, b8.done}, 2'b00);

    // reset while bit 4 is in the cell
    b8.a_in = 8'h12; b8.b_in = 8'h34; b8.bin = 1'b0;
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_outputs", {b8.busy, b8.done, b8.bout, b8.fs_a, b8.fs_b, b8.fs_c}, 6'd0);
    check("midrun_rst_diff", b8.diff, 8'h00);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (b8.done) ndone++;
    end
    check("midrun_no_done", ndone, 0);
    run8(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          run4(4'(a), 4'(b), 1'(bi));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
